priority_encoder_rr: RTL and testbench
======================================

# priority_encoder_rr

Registered, parametrised priority encoder with a valid/ready output handshake. It is the next generation of the team's combinational `encoder`. It turns a 2**N-bit request vector `inVal` into an N-bit index `encode`, holds the result until a downstream consumer accepts it, and flags multi-request collisions. A compile-time option replaces fixed MSB-first priority with rotating (round-robin) priority for fair arbitration between request sources.

## Interface
- `N`, default 3: index width; request vector is 2**N bits (N = 1..6 supported).
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-high reset.
- `enable`  input  1  permits sampling of `inVal`; when low, no new result is captured.
- `inVal`  input  2**N  request vector, bit i = request i.
- `ready`  input  1  consumer accepts the current result this cycle.
- `encode`  output  N  registered index of the selected request.
- `grant`  output  2**N  registered one-hot of the selected request (`grant == 1 << encode` whenever `valid`).
- `valid`  output  1  `encode`/`grant`/`multi` hold a result not yet accepted.
- `multi`  output  1  more than one bit of `inVal` was set at capture.

## Operation
- Slot free: `free = !valid || ready`.
- Load: `load = enable && free`. On a load edge:
  - `inVal != 0`: capture the selected index into `encode`, the one-hot into `grant`, `multi = (popcount(inVal) > 1)`, and set `valid = 1`.
  - `inVal == 0`: `valid <= 0`. `encode`, `grant` and `multi` are cleared to 0.
- Hold: `valid && !ready` freezes `encode`, `grant`, `multi` and `valid`, regardless of `enable` or `inVal`.
- `enable` low with `free`: if `ready` accepted a result, `valid <= 0` and the data registers are cleared. Otherwise there is no change.
- Selection, fixed priority (default): the highest set bit wins (MSB-first), matching the legacy `encoder`.
- Priority pointer `ptr` (N bits) is internal, used only in round-robin mode.
- Reset has priority over every other condition and is applied the same cycle it is sampled.

## Timing
- Latency: 1 cycle. `inVal` sampled at edge k appears on `encode`/`valid` after edge k.
- Throughput: 1 result per cycle while `ready` is held high.
- Simultaneous accept and load (`valid && ready && enable`): the new result replaces the old one at the same edge, with no bubble.
- Reset values: `encode = 0`, `grant = 0`, `valid = 0`, `multi = 0`, `ptr = 0`.
- Reset mid-handshake: a pending unaccepted result is discarded. The first load is possible on the cycle after `reset` deasserts.
- `ready` while `!valid` is legal and has no effect beyond allowing a load.
- `inVal` must be stable only around the sampling edge. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `PRIORITY_ENCODER_RR_ROUND_ROBIN_EN`.
- Defined:
  - Selection picks the lowest set index at or above `ptr`, wrapping modulo 2**N.
  - On every load with `inVal != 0`, `ptr <= (selected + 1) mod 2**N`, wrapping 2**N-1 to 0.
  - `ptr` is unchanged on a hold, on an empty load, and while `enable` is low.
- Undefined: fixed MSB-first priority; `ptr` logic is not synthesised.

## Test plan
N = 3 throughout.
- Reset/idle: assert `reset` 2 cycles with `inVal = 8'hFF`, `enable = 1` -> all outputs 0. First edge after release -> `valid = 1`, `multi = 1`, `encode = 7` (fixed) / `0` (round-robin).
- Single requests: `ready = 1`; sweep `inVal = 1 << i` for i = 0..7, one per cycle -> `encode = i`, `grant = 1 << i`, `multi = 0`, one cycle later, back-to-back with no bubbles. Then `inVal = 0` -> `valid = 0`.
- Backpressure: `inVal = 8'b0010_0100`, `ready = 0` for 5 cycles while `inVal` changes to `8'h01`:
  - Fixed build: `encode = 5` held, `multi = 1`.
  - Round-robin build: `encode = 2` held, `multi = 1`.
  - Raise `ready` -> the next cycle shows `encode = 0`, `multi = 0`.
- Round-robin fairness (macro defined): `inVal = 8'hFF`, `ready = 1` for 10 cycles -> `encode` = 0,1,…,7,0,1. With `inVal = 8'b1000_0001` -> `encode` alternates 0,7,0,7.
- Enable gating: `valid = 1` result pending, `enable = 0`, `ready = 1` -> `valid` drops the next cycle. `inVal` changes while `enable = 0` -> no capture, and `ptr` is unchanged.
- Reset mid-operation: pending `encode = 3`, `ready = 0`, pulse `reset` one cycle -> all outputs and `ptr` read 0 the next cycle, and the result is never delivered.

Source files
------------

// File: rtl/priority_encoder_rr.sv
`default_nettype none
// ============================================================================
//  Module      : priority_encoder_rr
//  Description : Registered 2**N-to-N priority encoder with a valid/ready
//                output handshake and multi-request flag. Fixed MSB-first
//                priority by default. Defining PRIORITY_ENCODER_RR_ROUND_ROBIN_EN
//                switches to rotating (round-robin) priority.
//  Revision    : 1.0  initial release
// ============================================================================
module priority_encoder_rr #(
  parameter int N = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [2**N-1:0]   inVal,
  input  logic              ready,
  output logic [N-1:0]      encode,
  output logic [2**N-1:0]   grant,
  output logic              valid,
  output logic              multi
);

  localparam int c_WIDTH = 2**N;
  localparam logic [c_WIDTH-1:0] c_ONE = {{(c_WIDTH-1){1'b0}}, 1'b1};

  logic               w_free;
  logic               w_load;
  logic               w_any;
  logic               w_multi;
  logic [N-1:0]       w_sel;
  logic [c_WIDTH-1:0] w_onehot;

  // The output slot can take a new result when empty or being drained now.
  assign w_free   = !valid || ready;
  assign w_load   = enable && w_free;
  assign w_any    = |inVal;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_multi  = |(inVal & (inVal - c_ONE));
  assign w_onehot = c_ONE << w_sel;

`ifdef PRIORITY_ENCODER_RR_ROUND_ROBIN_EN
  logic [N-1:0] r_ptr;

  // Scan upward from the pointer, wrapping; the first set request wins.
  always_comb begin
    logic         found;
    logic [N-1:0] idx;
    w_sel = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < c_WIDTH; k++) begin
      idx = r_ptr + N'(k);
      if (!found && inVal[idx]) begin
        w_sel = idx;
        found = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner on each non-empty load only.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_load && w_any) begin
      r_ptr <= w_sel + N'(1);
    end
  end
`else
  // Fixed priority: ascending scan so the highest set bit is the last written.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < c_WIDTH; i++) begin
      if (inVal[i]) begin
        w_sel = N'(i);
      end
    end
  end
`endif

  // Output register: capture on load, freeze while stalled, clear when drained.
  always_ff @(posedge clk) begin
    if (reset) begin
      encode <= '0;
      grant  <= '0;
      valid  <= 1'b0;
      multi  <= 1'b0;
    end else if (w_load) begin
      if (w_any) begin
        encode <= w_sel;
        grant  <= w_onehot;
        valid  <= 1'b1;
        multi  <= w_multi;
      end else begin
        encode <= '0;
        grant  <= '0;
        valid  <= 1'b0;
        multi  <= 1'b0;
      end
    end else if (valid && ready) begin
      // Accepted with enable low: nothing replaces the drained result.
      encode <= '0;
      grant  <= '0;
      valid  <= 1'b0;
      multi  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_priority_encoder_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_priority_encoder_rr
//  Description : Self-checking bench for priority_encoder_rr (N = 3): directed
//                vector table, hand-written fairness sequences, and randomized
//                traffic against a behavioural reference model. Follows
//                PRIORITY_ENCODER_RR_ROUND_ROBIN_EN to pick the expected policy.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_priority_encoder_rr;

  localparam int N = 3;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic [W-1:0] inv = '0;
  logic         rdy = 1'b0;
  logic [N-1:0] encode;
  logic [W-1:0] grant;
  logic         valid;
  logic         multi;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  logic         m_v   = 1'b0;
  logic [N-1:0] m_e   = '0;
  logic [W-1:0] m_g   = '0;
  logic         m_m   = 1'b0;
  int           m_ptr = 0;

  typedef struct {
    logic         r;
    logic         e;
    logic [W-1:0] in;
    logic         y;
    logic         xv;
    int           xef;
    int           xer;
    logic         xm;
  } vec_t;

  vec_t tbl[26];

  priority_encoder_rr #(.N(N)) dut (
    .clk   (clk),
    .reset (rst),
    .enable(en),
    .inVal (inv),
    .ready (rdy),
    .encode(encode),
    .grant (grant),
    .valid (valid),
    .multi (multi)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Winner from the policy rules: MSB-first, or first set at/above ptr modulo 8.
  function automatic int ref_select(input logic [W-1:0] v, input int ptr);
`ifdef PRIORITY_ENCODER_RR_ROUND_ROBIN_EN
    for (int k = 0; k < W; k++) if (v[(ptr + k) % W]) return (ptr + k) % W;
`else
    for (int i = W - 1; i >= 0; i--) if (v[i]) return i;
`endif
    return 0;
  endfunction

  task automatic model_clear();
    m_v = 1'b0; m_e = '0; m_g = '0; m_m = 1'b0;
  endtask

  task automatic model_edge();
    int  s;
    logic free;
    if (rst) begin
      model_clear();
      m_ptr = 0;
    end else begin
      free = !m_v || rdy;
      if (en && free) begin
        if (inv != 0) begin
          s     = ref_select(inv, m_ptr);
          m_v   = 1'b1;
          m_e   = N'(s);
          m_g   = W'(1) << s;
          m_m   = ($countones(inv) > 1);
          m_ptr = (s + 1) % W;
        end else begin
          model_clear();
        end
      end else if (free && m_v) begin
        model_clear();
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [W-1:0] v, input logic y);
    rst = r; en = e; inv = v; rdy = y;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic int pick(input int ef, input int er);
`ifdef PRIORITY_ENCODER_RR_ROUND_ROBIN_EN
    return er;
`else
    return ef;
`endif
  endfunction

  task automatic check_out(input string tag, input logic xv, input int xe, input logic xm);
    logic [W-1:0] xg;
    xg = xv ? (W'(1) << xe) : '0;
    check({tag, ".valid"},  32'(valid),  32'(xv));
    check({tag, ".encode"}, 32'(encode), 32'(xv ? xe : 0));
    check({tag, ".grant"},  32'(grant),  32'(xg));
    check({tag, ".multi"},  32'(multi),  32'(xm));
  endtask

  initial begin
    // Directed table: inputs before the edge, outputs expected after it.
    tbl[0]  = '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 0, 0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 0, 0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 7, 0, 1'b1};
    for (int i = 0; i < 8; i++)
      tbl[3 + i] = '{1'b0, 1'b1, 8'(1 << i), 1'b1, 1'b1, i, i, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 0, 0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 8'h24, 1'b0, 1'b1, 5, 2, 1'b1};
    for (int i = 13; i <= 16; i++)
      tbl[i] = '{1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 5, 2, 1'b1};
    tbl[17] = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 0, 0, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 0, 0, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 8'h10, 1'b1, 1'b0, 0, 0, 1'b0};
    tbl[20] = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 4, 4, 1'b1};
    tbl[21] = '{1'b0, 1'b1, 8'h08, 1'b1, 1'b1, 3, 3, 1'b0};
    tbl[22] = '{1'b0, 1'b1, 8'h08, 1'b0, 1'b1, 3, 3, 1'b0};
    tbl[23] = '{1'b1, 1'b1, 8'h08, 1'b0, 1'b0, 0, 0, 1'b0};
    tbl[24] = '{1'b0, 1'b0, 8'h08, 1'b1, 1'b0, 0, 0, 1'b0};
    tbl[25] = '{1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 7, 0, 1'b1};

    for (int i = 0; i < 26; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].in, tbl[i].y);
      check_out($sformatf("vec%0d", i), tbl[i].xv, pick(tbl[i].xef, tbl[i].xer), tbl[i].xm);
    end

    // Fairness with every source requesting: rotates 0..7,0,1 (fixed: always 7).
    step(1'b1, 1'b1, 8'hFF, 1'b1);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, 8'hFF, 1'b1);
      check_out($sformatf("fairFF%0d", k), 1'b1, pick(7, k % 8), 1'b1);
    end

    // Two contending sources alternate 0,7,0,7 (fixed: always 7).
    step(1'b1, 1'b1, 8'h81, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 8'h81, 1'b1);
      check_out($sformatf("fair81_%0d", k), 1'b1, pick(7, (k % 2 == 0) ? 0 : 7), 1'b1);
    end

    // Randomized traffic against the reference model.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int c = 0; c < 400; c++) begin
      logic [W-1:0] v;
      case ($urandom_range(0, 3))
        0:       v = '0;
        1:       v = W'(1) << $urandom_range(0, 7);
        default: v = W'($urandom);
      endcase
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), v, $urandom_range(0, 1) == 1);
      check($sformatf("rand%0d", c), 32'({valid, encode, grant, multi}), 32'({m_v, m_e, m_g, m_m}));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
